// File: rtl/sigma_delta_decimator_pkg.sv
// Shared helpers for the sigma-delta decimator: CIC width/shift arithmetic
// and signed saturation.
package sd_pkg;

  function automatic int cic_width(input int order, input int dec_log2);
    return order * dec_log2 + 2;
  endfunction

  function automatic int cic_shift(input int bw, input int order, input int dec_log2);
    return bw - 1 - order * dec_log2;
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int bw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bw - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/sigma_delta_decimator_if.sv
// PCM output handshake of the decimator: sample, valid/ready and sticky overrun.
interface sigma_delta_decimator_if #(parameter int BW = 16) ();
  logic [BW-1:0] sample_o;
  logic          valid_o;
  logic          ready_i;
  logic          overrun_o;

  modport master (output sample_o, output valid_o, output overrun_o, input ready_i);
  modport slave  (input sample_o, input valid_o, input overrun_o, output ready_i);
endinterface

// File: rtl/sigma_delta_decimator_comb.sv
// One CIC differentiator: dout = din - din(previous strobe), delay loads on strobe.
module cic_comb_stage #(
  parameter int W = 17
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         strobe_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o
);

  logic [W-1:0] dly_q;
  logic [W-1:0] dly_d;

  always_comb begin
    dly_d = dly_q;
    if (strobe_i) dly_d = din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) dly_q <= '0;
    else       dly_q <= dly_d;
  end

  assign dout_o = din_i - dly_q;

endmodule

// File: rtl/sigma_delta_decimator.sv
// 1-bit bitstream to signed PCM via a sinc^3 CIC decimator, with a
// valid/ready output register and sticky overrun flag.
module sigma_delta_decimator
  import sd_pkg::*;
#(
  parameter int BW       = 16,
  parameter int DEC_LOG2 = 5,
  parameter int ORDER    = 3,
  parameter bit INVERT   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic bit_i,
  sigma_delta_decimator_if.master pcm
);

  localparam int W  = cic_width(ORDER, DEC_LOG2);
  localparam int S  = cic_shift(BW, ORDER, DEC_LOG2);
  localparam int SW = $clog2(ORDER + 1);
  localparam logic [SW-1:0] SETTLE_DONE = SW'(ORDER);

  logic [W-1:0]        i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [DEC_LOG2-1:0] cnt_q, cnt_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [BW-1:0]       sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;

  logic [W-1:0]        x;
  logic                strobe;
  logic                load;
  logic [W-1:0]        comb [0:ORDER-1];
  logic signed [63:0]  c3_ext;
  logic signed [63:0]  y_wide;
  logic [BW-1:0]       y_sat;

  assign x = (bit_i ^ INVERT) ? W'(1) : '1;

  for (genvar g = 0; g < ORDER; g++) begin : g_comb
    if (g == 0) begin : g_first
      cic_comb_stage #(.W(W)) u_comb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .strobe_i(strobe),
        .din_i   (i3_q),
        .dout_o  (comb[g])
      );
    end else begin : g_next
      cic_comb_stage #(.W(W)) u_comb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .strobe_i(strobe),
        .din_i   (comb[g-1]),
        .dout_o  (comb[g])
      );
    end
  end

  // Wrapped W-bit comb result is a valid signed value; widen before scaling.
  assign c3_ext = {{(64 - W){comb[ORDER-1][W-1]}}, comb[ORDER-1]};

  if (S >= 0) begin : g_shl
    assign y_wide = c3_ext <<< S;
  end else begin : g_shr
    assign y_wide = c3_ext >>> (-S);
  end

  assign y_sat = BW'(sat_signed(y_wide, BW));

  always_comb begin
    i1_d      = i1_q;
    i2_d      = i2_q;
    i3_d      = i3_q;
    cnt_d     = cnt_q;
    settle_d  = settle_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    strobe = en_i && (cnt_q == '1);
    load   = strobe && (settle_q == SETTLE_DONE);

    if (en_i) begin
      i1_d  = i1_q + x;
      i2_d  = i2_q + i1_q;
      i3_d  = i3_q + i2_q;
      cnt_d = cnt_q + 1'b1;
    end

    if (strobe && (settle_q != SETTLE_DONE)) settle_d = settle_q + 1'b1;

    if (load) begin
      sample_d = y_sat;
      valid_d  = 1'b1;
      if (valid_q && !pcm.ready_i) overrun_d = 1'b1;
    end else if (valid_q && pcm.ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i1_q      <= '0;
      i2_q      <= '0;
      i3_q      <= '0;
      cnt_q     <= '0;
      settle_q  <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      i3_q      <= i3_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign pcm.sample_o  = sample_q;
  assign pcm.valid_o   = valid_q;
  assign pcm.overrun_o = overrun_q;

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Scoreboard bench for sigma_delta_decimator: stimulus queues expected samples,
// a posedge monitor pops and checks value and arrival edge on each accept.
module tb_sigma_delta_decimator;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic en_i = 1'b0;
  logic bit_i = 1'b0;

  always #5 clk = ~clk;

  sigma_delta_decimator_if #(.BW(16)) pcm ();

  sigma_delta_decimator #(
    .BW(16),
    .DEC_LOG2(5),
    .ORDER(3),
    .INVERT(1'b0)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .en_i (en_i),
    .bit_i(bit_i),
    .pcm  (pcm)
  );

  typedef struct {
    int val;
    int edge_no;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int edge_cnt = 0;

  always @(posedge clk) begin
    exp_t e;
    int got;
    if (rst_i) begin
      edge_cnt = 0;
    end else begin
      if (pcm.valid_o && pcm.ready_i) begin
        got = int'($signed(pcm.sample_o));
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_sample: got %0d at edge %0d, required no output", got, edge_cnt);
        end else begin
          e = q.pop_front();
          if (got != e.val) begin
            bad++;
            $display("FAIL sample_value: got %0d, required %0d (edge %0d)", got, e.val, edge_cnt);
          end
          if (e.edge_no >= 0) begin
            total++;
            if (edge_cnt != e.edge_no) begin
              bad++;
              $display("FAIL sample_edge: got edge %0d, required edge %0d", edge_cnt, e.edge_no);
            end
          end
        end
      end
      edge_cnt++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    en_i  = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_sample", int'($signed(pcm.sample_o)), 0);
    check("rst_valid", int'(pcm.valid_o), 0);
    check("rst_overrun", int'(pcm.overrun_o), 0);
  endtask

  // pattern pa for enabled-sample index < sw, pb afterwards; period-4 patterns
  task automatic run_stream(input logic [3:0] pa, input logic [3:0] pb, input int sw,
                            input int j0, input int n, input int en_div);
    logic [3:0] p;
    int e;
    for (int j = j0; j < j0 + n; j++) begin
      e = (en_div == 2) ? j / 2 : j;
      p = (e < sw) ? pa : pb;
      en_i  = (en_div == 2) ? ((j % 2) == 0) : 1'b1;
      bit_i = p[3 - (e % 4)];
      tick();
    end
  endtask

  task automatic drain();
    en_i = 1'b0;
    tick();
    tick();
    check("drain_empty", q.size(), 0);
  endtask

  task automatic run_case(input logic [3:0] pat, input int nstrobes, input int exp_val, input int en_div);
    exp_t e;
    for (int k = 4; k <= nstrobes; k++) begin
      e.val = exp_val;
      e.edge_no = (en_div == 1) ? 32 * k : 64 * k - 1;
      q.push_back(e);
    end
    pcm.ready_i = 1'b1;
    apply_reset();
    run_stream(pat, pat, 0, 0, nstrobes * 32 * en_div, en_div);
    drain();
  endtask

  initial begin
    exp_t e;
    pcm.ready_i = 1'b0;
    tick();

    run_case(4'b1111, 8, 32767, 1);
    run_case(4'b0000, 8, -32768, 1);
    check("const0_overrun", int'(pcm.overrun_o), 0);
    run_case(4'b1010, 6, 0, 1);
    run_case(4'b1110, 6, 16384, 1);
    run_case(4'b1111, 6, 32767, 2);

    // overrun: -1 input for 128 cycles then +1; strobe 5 sees 29 ones
    pcm.ready_i = 1'b0;
    apply_reset();
    run_stream(4'b0000, 4'b1111, 128, 0, 128, 1);
    check("ovr_first_valid", int'(pcm.valid_o), 1);
    check("ovr_first_sample", int'($signed(pcm.sample_o)), -32768);
    check("ovr_first_flag", int'(pcm.overrun_o), 0);
    run_stream(4'b0000, 4'b1111, 128, 128, 32, 1);
    en_i = 1'b0;
    check("ovr_valid", int'(pcm.valid_o), 1);
    check("ovr_sample", int'($signed(pcm.sample_o)), -23778);
    check("ovr_flag", int'(pcm.overrun_o), 1);
    e.val = -23778;
    e.edge_no = -1;
    q.push_back(e);
    pcm.ready_i = 1'b1;
    tick();
    pcm.ready_i = 1'b0;
    check("ovr_valid_drop", int'(pcm.valid_o), 0);
    check("ovr_flag_sticky", int'(pcm.overrun_o), 1);
    check("ovr_q_empty", q.size(), 0);

    // load and accept in the same cycle
    e.val = -32768;
    e.edge_no = -1;
    q.push_back(e);
    q.push_back(e);
    apply_reset();
    run_stream(4'b0000, 4'b0000, 0, 0, 159, 1);
    en_i = 1'b1;
    bit_i = 1'b0;
    pcm.ready_i = 1'b1;
    tick();
    en_i = 1'b0;
    check("sim_valid", int'(pcm.valid_o), 1);
    check("sim_overrun", int'(pcm.overrun_o), 0);
    tick();
    pcm.ready_i = 1'b0;
    check("sim_valid_drop", int'(pcm.valid_o), 0);
    check("sim_q_empty", q.size(), 0);

    // long run with wrapping integrators, ends mid-frame
    for (int k = 4; k <= 625; k++) begin
      e.val = 32767;
      e.edge_no = 32 * k;
      q.push_back(e);
    end
    pcm.ready_i = 1'b1;
    apply_reset();
    run_stream(4'b1111, 4'b1111, 0, 0, 20005, 1);
    check("long_q_empty", q.size(), 0);
    check("long_hold_sample", int'($signed(pcm.sample_o)), 32767);
    run_case(4'b1111, 4, 32767, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
